// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Width of the wait-state counter (wait counts 0..15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word array: synchronous write, combinational read.
// Contents are intentionally not reset.
module mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Word write on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU memory interface: one request at a time,
// per-type wait states, valid/ready on request and response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  addr_err;
  logic                  commit;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Range check over the full address: any bit above the storage index is an error
  assign addr_err = (addr_q >> DEPTH_LOG2) != '0;
  // Commit happens on the edge that leaves WAIT with the counter exhausted
  assign commit   = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_we   = commit && we_q && !addr_err;

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q[DEPTH_LOG2-1:0]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  // Next-state, request latching, counter and response updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // A zero count makes the very next edge the commit edge
          cnt_d   = req_we ? CNT_W'(WRITE_WAIT) : CNT_W'(READ_WAIT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_rdata_d = (we_q || addr_err) ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default waits (dut) and zero read wait (dut0).
module tb_mem_responder;

  localparam int LIMIT = 20;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        req_valid0, req_we0, rsp_ready0;
  logic [15:0] req_addr0, req_wdata0;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [15:0] rsp_rdata0;

  int n_assert = 0;
  int n_fail   = 0;

  int          lat;
  logic [15:0] rd;
  logic        er;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  mem_responder #(.READ_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .busy(busy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut; lat counts edges from acceptance to rsp_valid.
  task automatic xact(input string tag, input logic we, input logic [15:0] a,
                      input logic [15:0] wd, output int l, output logic [15:0] r,
                      output logic e);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_we = ~we; req_addr = 16'hFFFF; req_wdata = 16'hDEAD;
    l = 0;
    while (!rsp_valid && l < LIMIT) begin
      step();
      l++;
    end
    chk({tag, "_timeout"}, 16'(l < LIMIT), 16'd1);
    r = rsp_rdata;
    e = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, 16'(rsp_valid), 16'd0);
    chk({tag, "_ready_back"}, 16'(req_ready), 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 0;

    // Reset state, with ready visible while rst is asserted
    #2;
    chk("rst_ready", 16'(req_ready), 16'd1);
    chk("rst_valid", 16'(rsp_valid), 16'd0);
    chk("rst_err",   16'(rsp_err),   16'd0);
    chk("rst_rdata", rsp_rdata,      16'h0000);
    chk("rst_busy",  16'(busy),      16'd0);
    step(); step();
    rst = 1'b0;

    // 1: reset in the middle of a write's wait
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'h1234;
    step();
    req_valid = 1'b0;
    chk("t1_busy", 16'(busy), 16'd1);
    chk("t1_notready", 16'(req_ready), 16'd0);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_valid", 16'(rsp_valid), 16'd0);
    chk("t1_rst_ready", 16'(req_ready), 16'd1);
    chk("t1_rst_err",   16'(rsp_err),   16'd0);
    chk("t1_rst_rdata", rsp_rdata,      16'h0000);
    step();
    rst = 1'b0;
    xact("t1_rd5", 1'b0, 16'd5, 16'h0, lat, rd, er);
    chk("t1_rd5_lat", 16'(lat), 16'd3);
    chk("t1_rd5_dropped", 16'(rd !== 16'h1234), 16'd1);

    // 2: write then read
    xact("t2_wr", 1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
    chk("t2_wr_lat", 16'(lat), 16'd2);
    chk("t2_wr_rdata", rd, 16'h0000);
    chk("t2_wr_err", 16'(er), 16'd0);
    xact("t2_rd", 1'b0, 16'h0010, 16'h0, lat, rd, er);
    chk("t2_rd_lat", 16'(lat), 16'd3);
    chk("t2_rd_rdata", rd, 16'hBEEF);
    chk("t2_rd_err", 16'(er), 16'd0);

    // 3: backpressure, with a second request held during the response
    xact("t3_wr", 1'b1, 16'h0020, 16'h00A5, lat, rd, er);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
    step();
    req_addr = 16'h0010;
    step(); step(); step();
    chk("t3_valid", 16'(rsp_valid), 16'd1);
    chk("t3_rdata", rsp_rdata, 16'h00A5);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_valid", 16'(rsp_valid), 16'd1);
      chk("t3_hold_rdata", rsp_rdata, 16'h00A5);
      chk("t3_hold_notready", 16'(req_ready), 16'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t3_hs_valid", 16'(rsp_valid), 16'd0);
    chk("t3_hs_notaccepted", 16'(req_ready), 16'd1);
    chk("t3_hs_rdata_kept", rsp_rdata, 16'h00A5);
    step();
    req_valid = 1'b0;
    chk("t3_second_accept", 16'(busy), 16'd1);
    step(); step(); step();
    chk("t3_second_valid", 16'(rsp_valid), 16'd1);
    chk("t3_second_rdata", rsp_rdata, 16'hBEEF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // 4: out-of-range address must not alias onto word 0
    xact("t4_wr0", 1'b1, 16'h0000, 16'h1111, lat, rd, er);
    xact("t4_wroor", 1'b1, 16'h0100, 16'h5555, lat, rd, er);
    chk("t4_wroor_err", 16'(er), 16'd1);
    chk("t4_wroor_rdata", rd, 16'h0000);
    xact("t4_rdoor", 1'b0, 16'h0100, 16'h0, lat, rd, er);
    chk("t4_rdoor_err", 16'(er), 16'd1);
    chk("t4_rdoor_rdata", rd, 16'h0000);
    xact("t4_rdhigh", 1'b0, 16'h8005, 16'h0, lat, rd, er);
    chk("t4_rdhigh_err", 16'(er), 16'd1);
    xact("t4_rd0", 1'b0, 16'h0000, 16'h0, lat, rd, er);
    chk("t4_rd0_err", 16'(er), 16'd0);
    chk("t4_rd0_rdata", rd, 16'h1111);

    // 6: top edge address
    xact("t6_wrff", 1'b1, 16'h00FF, 16'hCAFE, lat, rd, er);
    chk("t6_wrff_err", 16'(er), 16'd0);
    xact("t6_rdff", 1'b0, 16'h00FF, 16'h0, lat, rd, er);
    chk("t6_rdff_err", 16'(er), 16'd0);
    chk("t6_rdff_rdata", rd, 16'hCAFE);

    // 5: zero read wait on dut0; preload two words
    for (int k = 3; k <= 4; k++) begin
      req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 16'(k); req_wdata0 = 16'(k * 16'h0101);
      step();
      req_valid0 = 1'b0;
      step(); step();
      chk("t5_wr_valid", 16'(rsp_valid0), 16'd1);
      rsp_ready0 = 1'b1;
      step();
      rsp_ready0 = 1'b0;
    end
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 16'd3; rsp_ready0 = 1'b1;
    step();
    req_addr0 = 16'd4;
    chk("t5_a_accept", 16'(busy0), 16'd1);
    chk("t5_a_novalid", 16'(rsp_valid0), 16'd0);
    step();
    chk("t5_a_valid", 16'(rsp_valid0), 16'd1);
    chk("t5_a_rdata", rsp_rdata0, 16'h0303);
    step();
    chk("t5_a_hs", 16'(rsp_valid0), 16'd0);
    chk("t5_a_idle", 16'(req_ready0), 16'd1);
    step();
    chk("t5_b_accept", 16'(busy0), 16'd1);
    step();
    req_valid0 = 1'b0;
    chk("t5_b_valid", 16'(rsp_valid0), 16'd1);
    chk("t5_b_rdata", rsp_rdata0, 16'h0404);
    chk("t5_b_err", 16'(rsp_err0), 16'd0);
    step();
    rsp_ready0 = 1'b0;
    chk("t5_b_idle", 16'(req_ready0), 16'd1);

    // Reset with a response outstanding: valid falls without a clock edge
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("rr_valid_before", 16'(rsp_valid), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("rr_valid_async", 16'(rsp_valid), 16'd0);
    chk("rr_rdata_async", rsp_rdata, 16'h0000);
    step();
    rst = 1'b0;
    xact("rr_rd", 1'b0, 16'h0010, 16'h0, lat, rd, er);
    chk("rr_persist", rd, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
